// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// instruction_fetch_unit
// ----------------------------------------------------------------------------
// IF stage of the 5-stage LEGv8 pipeline.
//
// It owns the fetch PC and fetches from instruction memory over a req/ack
// handshake. It writes the IF/ID pipeline register that decode consumes, and
// it applies decode-stage branch redirects plus hazard stalls and flushes.
//
// Optional feature macro: FETCH_PERF_EN
//   When defined, the FetchBubbleCnt output is added. It is a saturating count
//   of edges where the IF/ID register receives a bubble while not stalled.
//
// Parameters
//   ADDR_W    PC / address width
//   RESET_PC  PC loaded on reset; first fetch address
//
// Ports
//   clk            clock, all state updates on posedge
//   reset          asynchronous active-low reset
//   StallF         hazard stall: hold PC and IF/ID register
//   FlushD         clear ValidD on the next edge
//   BrTakenD       branch taken in decode, redirect fetch to pcBrD
//   pcBrD          branch target (used as given, may be unaligned)
//   imem_req       fetch request valid
//   imem_addr      fetch address, stable while imem_req && !imem_ack
//   imem_ack       memory returns imem_rdata this cycle
//   imem_rdata     instruction word, valid with imem_ack
//   InstrD         IF/ID instruction
//   pcD            IF/ID PC of InstrD
//   ValidD         IF/ID holds a real instruction (0 = bubble)
//   FetchBubbleCnt bubble counter (only with FETCH_PERF_EN)
// ============================================================================
module instruction_fetch_unit #(
    parameter int                 ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallF,
    input  logic              FlushD,
    input  logic              BrTakenD,
    input  logic [ADDR_W-1:0] pcBrD,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       InstrD,
    output logic [ADDR_W-1:0] pcD,
    output logic              ValidD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       FetchBubbleCnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HELD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] pc_f;
    logic [ADDR_W-1:0] pc_f_n;
    logic [ADDR_W-1:0] drop_addr;
    logic [ADDR_W-1:0] drop_addr_n;
    logic              skid_valid;
    logic              skid_valid_n;
    logic [31:0]       skid_instr;
    logic [31:0]       skid_instr_n;
    logic [ADDR_W-1:0] skid_pc;
    logic [ADDR_W-1:0] skid_pc_n;
    logic [31:0]       instr_n;
    logic [ADDR_W-1:0] pc_d_n;
    logic              valid_n;
    logic              req_n;
    logic [ADDR_W-1:0] addr_n;

`ifdef FETCH_PERF_EN
    logic [31:0]       bubble_cnt_n;
`endif

    // Next-state logic. Priority is redirect > flush > stall > normal.
    // By default the IF/ID register holds under a stall and otherwise
    // receives a bubble; only an accepted word turns ValidD on.
    always_comb begin
        state_n      = state;
        pc_f_n       = pc_f;
        drop_addr_n  = drop_addr;
        skid_valid_n = skid_valid;
        skid_instr_n = skid_instr;
        skid_pc_n    = skid_pc;
        instr_n      = InstrD;
        pc_d_n       = pcD;
        valid_n      = StallF ? ValidD : 1'b0;

        if (BrTakenD) begin
            pc_f_n       = pcBrD;
            valid_n      = 1'b0;
            skid_valid_n = 1'b0;
            // An un-acked request cannot be withdrawn without breaking the
            // handshake, so it is finished in DROP and its word thrown away.
            if (imem_req && !imem_ack) begin
                state_n     = DROP;
                drop_addr_n = imem_addr;
            end else begin
                state_n = FETCH;
            end
        end else begin
            case (state)
                IDLE: begin
                    state_n = FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        pc_f_n = pc_f + PC_STEP;
                        if (StallF) begin
                            // Decode cannot take the word now; park it.
                            skid_valid_n = 1'b1;
                            skid_instr_n = imem_rdata;
                            skid_pc_n    = pc_f;
                            state_n      = HELD;
                        end else begin
                            instr_n = imem_rdata;
                            pc_d_n  = pc_f;
                            valid_n = 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (!StallF) begin
                        instr_n      = skid_instr;
                        pc_d_n       = skid_pc;
                        valid_n      = skid_valid;
                        skid_valid_n = 1'b0;
                        state_n      = FETCH;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state_n = FETCH;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase

            if (FlushD) begin
                valid_n = 1'b0;
            end
        end

        // The memory-side outputs are registered from the next state so they
        // come straight from flops and drop asynchronously on reset.
        req_n  = (state_n == FETCH) || (state_n == DROP);
        addr_n = (state_n == DROP) ? drop_addr_n : pc_f_n;
    end

`ifdef FETCH_PERF_EN
    // Counts bubble edges that are not simply a stalled hold; saturates.
    always_comb begin
        bubble_cnt_n = FetchBubbleCnt;
        if (!valid_n && !StallF && (FetchBubbleCnt != 32'hFFFF_FFFF)) begin
            bubble_cnt_n = FetchBubbleCnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            FetchBubbleCnt <= 32'd0;
        end else begin
            FetchBubbleCnt <= bubble_cnt_n;
        end
    end
`endif

    // Fetch FSM, PC, skid buffer and IF/ID register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc_f       <= RESET_PC;
            drop_addr  <= RESET_PC;
            skid_valid <= 1'b0;
            skid_instr <= 32'h0;
            skid_pc    <= RESET_PC;
            InstrD     <= 32'h0;
            pcD        <= RESET_PC;
            ValidD     <= 1'b0;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
        end else begin
            state      <= state_n;
            pc_f       <= pc_f_n;
            drop_addr  <= drop_addr_n;
            skid_valid <= skid_valid_n;
            skid_instr <= skid_instr_n;
            skid_pc    <= skid_pc_n;
            InstrD     <= instr_n;
            pcD        <= pc_d_n;
            ValidD     <= valid_n;
            imem_req   <= req_n;
            imem_addr  <= addr_n;
        end
    end

endmodule
